// File: rtl/updown_sync_counter.sv
// Parametrised up/down binary counter with synchronous clear/load, wrap or
// saturate at the boundaries, terminal-count/carry for cascading and a sticky wrap flag.
module updown_sync_counter #(
   parameter int                WIDTH     = 8,
   parameter logic [WIDTH-1:0]  MAX_COUNT = {WIDTH{1'b1}},
   parameter int                SATURATE  = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             count_enable,
   input  logic             up_down,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] Q,
   output logic             terminal_count,
   output logic             carry_out,
   output logic             wrapped
);

   logic [WIDTH-1:0] q_d, q_q;
   logic             wrapped_d, wrapped_q;
   logic             at_max, at_zero;

   assign at_max  = (q_q == MAX_COUNT);
   assign at_zero = (q_q == '0);

   always_comb begin
      q_d       = q_q;
      wrapped_d = wrapped_q;
      if (clear) begin
         q_d       = '0;
         wrapped_d = 1'b0;
      end else if (load) begin
         q_d = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
      end else if (count_enable) begin
         if (up_down) begin
            if (at_max) begin
               wrapped_d = 1'b1;
               q_d       = (SATURATE != 0) ? q_q : '0;
            end else begin
               q_d = q_q + WIDTH'(1);
            end
         end else begin
            if (at_zero) begin
               wrapped_d = 1'b1;
               q_d       = (SATURATE != 0) ? q_q : MAX_COUNT;
            end else begin
               q_d = q_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_q       <= '0;
         wrapped_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         wrapped_q <= wrapped_d;
      end
   end

   // Boundary depends on the live direction so a cascade reacts within the cycle.
   assign terminal_count = up_down ? at_max : at_zero;
   assign carry_out      = terminal_count & count_enable;
   assign Q              = q_q;
   assign wrapped        = wrapped_q;

endmodule
